// File: rtl/shift_pkg.sv
// Shared shifter definitions: operand width, shift-amount type and the
// signed-overflow predicate used by the left shifter's optional overflow flag.
package shift_pkg;

  localparam int SHIFT_W = 64;
  localparam int SHAMT_W = 6;

  typedef logic [SHAMT_W-1:0] shamt_t;

  typedef struct packed {
    logic               valid;
    logic [SHIFT_W-1:0] data;
  } stage_t;

  // A left shift by s loses sign information when d[63:63-s] are not all
  // equal; flipping against the sign bit turns that into a nonzero test.
  function automatic logic signed_ovf(input logic [SHIFT_W-1:0] d,
                                      input shamt_t             s);
    logic [SHIFT_W-1:0] diff;
    shamt_t             low;
    diff = d ^ {SHIFT_W{d[SHIFT_W-1]}};
    low  = shamt_t'(SHIFT_W-1) - s;
    return (diff >> low) != '0;
  endfunction

endpackage

// File: rtl/sll_64b_pipe_if.sv
// Operand/result bundle for the pipelined 64-bit left shifter.
// ovf_o exists only when SLL_64B_OVF_EN is defined.
interface sll_64b_pipe_if;
  import shift_pkg::*;

  logic               init_i;
  logic               arith_i;
  logic [SHIFT_W-1:0] shift_i;
  logic [SHIFT_W-1:0] data_i;
  logic               done_o;
  logic [SHIFT_W-1:0] data_o;
`ifdef SLL_64B_OVF_EN
  logic               ovf_o;
`endif

  modport master (
    output init_i, arith_i, shift_i, data_i,
    input  done_o, data_o
`ifdef SLL_64B_OVF_EN
    , ovf_o
`endif
  );

  modport slave (
    input  init_i, arith_i, shift_i, data_i,
    output done_o, data_o
`ifdef SLL_64B_OVF_EN
    , ovf_o
`endif
  );

endinterface

// File: rtl/onehot2bin_64b.sv
// One-hot to binary encoder; highest set bit wins, all-zero input gives 0.
module onehot2bin_64b
  import shift_pkg::*;
(
  input  logic [SHIFT_W-1:0] onehot_i,
  output shamt_t             bin_o
);

  always_comb begin
    bin_o = '0;
    for (int k = 0; k < SHIFT_W; k++) begin
      if (onehot_i[k]) bin_o = shamt_t'(k);
    end
  end

endmodule

// File: rtl/sll_64b_pipe.sv
// Three-stage 64-bit logical left shifter (16/4/1 granularity per stage).
// Define SLL_64B_OVF_EN to add the signed-overflow flag ovf_o.
module sll_64b_pipe
  import shift_pkg::*;
#(
  parameter bit CLR_OUT = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  sll_64b_pipe_if.slave  bus
);

  shamt_t             shamt;
  stage_t             st1_q;
  stage_t             st2_q;
  logic [3:0]         s1_q;
  logic [1:0]         s2_q;
  logic               done_q;
  logic [SHIFT_W-1:0] data_q;

  onehot2bin_64b u_enc (
    .onehot_i (bus.shift_i),
    .bin_o    (shamt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st1_q  <= '0;
      st2_q  <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      done_q <= 1'b0;
      data_q <= '0;
    end else begin
      st1_q.valid <= bus.init_i;
      if (bus.init_i) begin
        st1_q.data <= bus.data_i << {shamt[5:4], 4'b0000};
        s1_q       <= shamt[3:0];
      end
      st2_q.valid <= st1_q.valid;
      st2_q.data  <= st1_q.data << {s1_q[3:2], 2'b00};
      s2_q        <= s1_q[1:0];
      done_q      <= st2_q.valid;
      // Result only lives for its done cycle unless the output is asked to hold.
      if (st2_q.valid)  data_q <= st2_q.data << s2_q;
      else if (CLR_OUT) data_q <= '0;
    end
  end

  assign bus.done_o = done_q;
  assign bus.data_o = data_q;

`ifdef SLL_64B_OVF_EN
  logic ovf1_q;
  logic ovf2_q;
  logic ovf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf1_q <= 1'b0;
      ovf2_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (bus.init_i) ovf1_q <= bus.arith_i & signed_ovf(bus.data_i, shamt);
      ovf2_q <= ovf1_q;
      ovf_q  <= st2_q.valid & ovf2_q;
    end
  end

  assign bus.ovf_o = ovf_q;
`else
  logic unused_arith;
  assign unused_arith = bus.arith_i;
`endif

endmodule

// File: tb/tb_sll_64b_pipe.sv
// Self-checking bench for sll_64b_pipe: vector table, hand sequences for
// back-to-back issue and reset, and random traffic against a reference model.
module tb_sll_64b_pipe;
  import shift_pkg::*;

  localparam bit CLR_OUT = 1'b1;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  sll_64b_pipe_if bus ();

  sll_64b_pipe #(.CLR_OUT(CLR_OUT)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    logic [63:0] data;
    logic        ovf;
  } exp_t;

  exp_t        q[$];
  logic [63:0] last_out = '0;

  logic        cap_en = 1'b0;
  logic [63:0] obs[$];
  int          obs_cyc[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: amount is the index of the top set bit; overflow means an
  // arithmetic shift back cannot recover the original signed operand.
  function automatic logic [63:0] ref_shift(input logic [63:0] sh, input logic [63:0] d,
                                            output logic lost_sign);
    int s = 0;
    for (int k = 0; k < 64; k++) if (sh[k]) s = k;
    lost_sign = ($signed(d << s) >>> s) != $signed(d);
    return d << s;
  endfunction

  always @(posedge clk_i) begin
    cyc++;
    if (rst_i) begin
      q.delete();
      last_out = '0;
    end else if (bus.init_i) begin
      exp_t e;
      logic ls;
      e.data = ref_shift(bus.shift_i, bus.data_i, ls);
      e.ovf  = bus.arith_i & ls;
      e.due  = cyc + 2;
      q.push_back(e);
    end
  end

  always @(negedge clk_i) begin
    logic        exp_done;
    logic [63:0] exp_data;
    logic        exp_ovf;
    exp_done = 1'b0;
    exp_data = CLR_OUT ? '0 : last_out;
    exp_ovf  = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_done = 1'b1;
      exp_data = q[0].data;
      exp_ovf  = q[0].ovf;
      void'(q.pop_front());
    end
    chk("mon_done", 64'(bus.done_o), 64'(exp_done));
    chk("mon_data", bus.data_o, exp_data);
`ifdef SLL_64B_OVF_EN
    chk("mon_ovf", 64'(bus.ovf_o), 64'(exp_ovf));
`endif
    if (exp_done) last_out = exp_data;
    if (cap_en && bus.done_o) begin
      obs.push_back(bus.data_o);
      obs_cyc.push_back(cyc);
    end
  end

  task automatic apply(input logic init, input logic arith, input logic [63:0] sh,
                       input logic [63:0] d);
    bus.init_i  = init;
    bus.arith_i = arith;
    bus.shift_i = sh;
    bus.data_i  = d;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 1'b0, '0, '0);
  endtask

  typedef struct {
    logic        arith;
    logic [63:0] shift;
    logic [63:0] data;
    logic [63:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  vec_t vt[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i       = 1'b1;
    bus.init_i  = 1'b0;
    bus.arith_i = 1'b0;
    bus.shift_i = '0;
    bus.data_i  = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_done", 64'(bus.done_o), 64'd0);
    chk("rst_data", bus.data_o, 64'd0);
    rst_i = 1'b0;

    vt.push_back('{1'b0, 64'h8000_0000_0000_0000, 64'h1,                   64'h8000_0000_0000_0000, 1'b0});
    vt.push_back('{1'b0, 64'h0,                   64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1'b0});
    vt.push_back('{1'b0, 64'h0000_0000_0010_0010, 64'h1,                   64'h0000_0000_0010_0000, 1'b0});
    vt.push_back('{1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0});
    vt.push_back('{1'b0, 64'h0000_0010_0000_0000, 64'hABCD,                64'h000A_BCD0_0000_0000, 1'b0});
    vt.push_back('{1'b0, 64'h20,                  64'h8000_0000_0000_0001, 64'h20,                  1'b0});
    vt.push_back('{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3,                   64'h8000_0000_0000_0000, 1'b0});
    vt.push_back('{1'b0, 64'h3,                   64'hF,                   64'h1E,                  1'b0});
    vt.push_back('{1'b1, 64'h2,                   64'h4000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1});
    vt.push_back('{1'b0, 64'h2,                   64'h4000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0});
    vt.push_back('{1'b1, 64'h2,                   64'hC000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0});
    vt.push_back('{1'b1, 64'h0,                   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0});
    vt.push_back('{1'b1, 64'h10,                  64'h0F00_0000_0000_0000, 64'hF000_0000_0000_0000, 1'b1});

    for (int i = 0; i < vt.size(); i++) begin
      int lat;
      apply(1'b1, vt[i].arith, vt[i].shift, vt[i].data);
      bus.init_i  = 1'b0;
      bus.arith_i = 1'b1;
      bus.shift_i = 64'h1;
      bus.data_i  = '1;
      lat = 0;
      while (lat < 6) begin
        @(negedge clk_i);
        lat++;
        if (bus.done_o) break;
      end
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
      chk($sformatf("vec%0d_data", i), bus.data_o, vt[i].exp_data);
`ifdef SLL_64B_OVF_EN
      chk($sformatf("vec%0d_ovf", i), 64'(bus.ovf_o), 64'(vt[i].exp_ovf));
`endif
      @(posedge clk_i);
      #1;
    end

    // back-to-back issue, shifts 1..4 on 0xF
    obs.delete();
    obs_cyc.delete();
    cap_en = 1'b1;
    apply(1'b1, 1'b0, 64'h2,  64'hF);
    apply(1'b1, 1'b0, 64'h4,  64'hF);
    apply(1'b1, 1'b0, 64'h8,  64'hF);
    apply(1'b1, 1'b0, 64'h10, 64'hF);
    idle(5);
    cap_en = 1'b0;
    chk("b2b_count", 64'(obs.size()), 64'd4);
    if (obs.size() == 4) begin
      chk("b2b_0", obs[0], 64'h1E);
      chk("b2b_1", obs[1], 64'h3C);
      chk("b2b_2", obs[2], 64'h78);
      chk("b2b_3", obs[3], 64'hF0);
      for (int i = 1; i < 4; i++)
        chk($sformatf("b2b_consec%0d", i), 64'(obs_cyc[i] - obs_cyc[0]), 64'(i));
    end

    // reset one cycle after init kills the operation
    obs.delete();
    obs_cyc.delete();
    cap_en = 1'b1;
    apply(1'b1, 1'b0, 64'h2, 64'h1);
    rst_i = 1'b1;
    apply(1'b0, 1'b0, '0, '0);
    rst_i = 1'b0;
    idle(5);
    cap_en = 1'b0;
    chk("rst_kill_count", 64'(obs.size()), 64'd0);
    chk("rst_kill_data", bus.data_o, 64'd0);

    // init during reset ignored; init right after reset accepted
    obs.delete();
    obs_cyc.delete();
    cap_en = 1'b1;
    rst_i = 1'b1;
    apply(1'b1, 1'b0, 64'h2, 64'h5);
    rst_i = 1'b0;
    apply(1'b1, 1'b0, 64'h4, 64'h5);
    idle(5);
    cap_en = 1'b0;
    chk("post_rst_count", 64'(obs.size()), 64'd1);
    if (obs.size() == 1) chk("post_rst_data", obs[0], 64'h14);

    for (int i = 0; i < 400; i++) begin
      logic [63:0] sh;
      int mode;
      rst_i = ($urandom_range(0, 59) == 0);
      mode  = $urandom_range(0, 3);
      case (mode)
        0:       sh = '0;
        1:       sh = 64'h1 << $urandom_range(0, 63);
        default: sh = {$urandom, $urandom};
      endcase
      apply(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), sh, {$urandom, $urandom});
    end
    rst_i = 1'b0;
    idle(6);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sll_64b_pipe.md
SLL_64B_PIPE -- requirements
Module: sll_64b_pipe

Interface
REQ-001 SHALL have parameter CLR_OUT, default 1: 1 = data_o forced to zero whenever done_o is low; 0 = data_o holds its last value.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-004 SHALL have port init_i, input, 1, start-of-operation strobe; one operation accepted per cycle.
REQ-005 SHALL have port done_o, output, 1, result-valid strobe.
REQ-006 SHALL have port arith_i, input, 1, selects signed-overflow checking (used only under REQ-021).
REQ-007 SHALL have port shift_i, input, 64, one-hot left-shift amount; bit k set = shift by k.
REQ-008 SHALL have port data_i, input, 64, operand.
REQ-009 SHALL have port data_o, output, 64, data_i shifted left, zero-filled.

Function
REQ-010 SHALL sample shift_i, data_i and arith_i only in a cycle where init_i=1; inputs in other cycles are ignored.
REQ-011 SHALL encode shift_i to a 6-bit amount s in the sampling cycle: the highest set bit wins when several are set; s=0 when all bits are zero.
REQ-012 SHALL compute the result in 3 registered stages: stage 1 shifts by 16*s[5:4], stage 2 by 4*s[3:2], stage 3 by s[1:0]; vacated LSBs are filled with 0.
REQ-013 SHALL assert done_o exactly 3 cycles after the init_i cycle (init at edge N -> done_o high after edge N+3), for one cycle per accepted operation.
REQ-014 SHALL carry a valid bit with each stage; back-to-back init_i on consecutive cycles SHALL produce done_o on consecutive cycles with results in issue order.
REQ-015 SHALL have no backpressure; done_o is not acknowledged and the result is present only in its done_o cycle.
REQ-016 SHALL, when CLR_OUT=1, drive data_o=0 in every cycle with done_o=0.
REQ-017 SHALL produce data_o=data_i for s=0 and data_o={data_i[0],63'b0} for s=63.

Reset
REQ-018 SHALL, while rst_i=1 at a clock edge, clear all stage valid bits, done_o, data_o and all stage data registers to 0.
REQ-019 SHALL discard every operation in flight when rst_i asserts; no done_o from a pre-reset init_i is produced after reset.
REQ-020 SHALL ignore init_i in any cycle where rst_i=1; an init_i in the first cycle after rst_i deasserts is accepted normally.

Configuration
REQ-021 SHALL, when SLL_64B_OVF_EN is defined, add output port ovf_o (1 bit), asserted together with done_o when arith_i was 1 at issue and data_i[63:63-s] are not all equal (signed overflow); ovf_o is 0 when done_o=0, when arith_i was 0, and after reset.
REQ-022 SHALL, when SLL_64B_OVF_EN is undefined, omit ovf_o and all overflow logic; the remaining behaviour is identical.

Structure
REQ-023 SHALL take SHIFT_W=64, SHAMT_W=6 and typedef shamt_t from the shared package shift_pkg, for reuse by the right shifter.
REQ-024 SHALL place the one-hot to binary encoder in sub-module onehot2bin_64b (combinational, highest-set-bit priority, zero input -> 0).

Verification
REQ-025 SHALL cover: init_i=1, data_i=64'h0000_0000_0000_0001, shift_i=1<<63 -> done_o after 3 cycles, data_o=64'h8000_0000_0000_0000.
REQ-026 SHALL cover: shift_i=0, data_i=64'hDEAD_BEEF_0123_4567 -> data_o=64'hDEAD_BEEF_0123_4567; shift_i=(1<<4)|(1<<20), data_i=64'h1 -> data_o=64'h0000_0000_0010_0000.
REQ-027 SHALL cover: init_i high for 4 consecutive cycles with shifts 1, 2, 3, 4 on data_i=64'hF -> done_o high for 4 consecutive cycles, data_o=64'h1E, 64'h3C, 64'h78, 64'hF0 in that order.
REQ-028 SHALL cover: rst_i pulsed 1 cycle after init_i -> no done_o follows; data_o stays 0.
REQ-029 SHALL cover, with SLL_64B_OVF_EN defined: arith_i=1, data_i=64'h4000_0000_0000_0000, shift 1 -> ovf_o=1; the same operation with arith_i=0 -> ovf_o=0; arith_i=1, data_i=64'hC000_0000_0000_0000, shift 1 -> ovf_o=0.
